// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and datapath-select encodings for the multi-cycle controller
package mc_ctrl_pkg;
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] FETCH     = 4'd1;
  localparam logic [3:0] DECODE    = 4'd2;
  localparam logic [3:0] MEM_ADDR  = 4'd3;
  localparam logic [3:0] MEM_READ  = 4'd4;
  localparam logic [3:0] MEM_WB    = 4'd5;
  localparam logic [3:0] MEM_WRITE = 4'd6;
  localparam logic [3:0] EXECUTE   = 4'd7;
  localparam logic [3:0] R_WB      = 4'd8;
  localparam logic [3:0] BRANCH    = 4'd9;
  localparam logic [3:0] ADDI_EXEC = 4'd10;
  localparam logic [3:0] ADDI_WB   = 4'd11;
  localparam logic [3:0] JUMP      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] aluOp;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic       instrDone;
  } ctrlWord_t;

  localparam int CTRL_W = $bits(ctrlWord_t);

  function automatic logic isSupported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction
endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: Moore control word per state, with memory-ready gating on stall states
module mc_output_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0]        state,
  input  logic              memReady,
  output logic [CTRL_W-1:0] ctrlWord
);
  ctrlWord_t c;
  // control word for the current state; unlisted signals stay 0
  always_comb begin
    c = '0;
    case (state)
      FETCH: begin
        c.memRead = 1'b1;
        c.aluSrcB = SRCB_FOUR;
        c.aluOp = ALUOP_ADD;
        c.pcSource = PCSRC_ALU;
        c.irWrite = memReady;
        c.pcWrite = memReady;
      end
      DECODE: begin
        c.aluSrcB = SRCB_IMMSH;
        c.aluOp = ALUOP_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp = ALUOP_ADD;
      end
      MEM_READ: begin
        c.memRead = 1'b1;
        c.iorD = 1'b1;
      end
      MEM_WB: begin
        c.regWrite = 1'b1;
        c.memtoReg = 1'b1;
        c.instrDone = 1'b1;
      end
      MEM_WRITE: begin
        c.memWrite = 1'b1;
        c.iorD = 1'b1;
        c.instrDone = memReady;
      end
      EXECUTE: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_B;
        c.aluOp = ALUOP_FUNCT;
      end
      R_WB: begin
        c.regWrite = 1'b1;
        c.regDst = 1'b1;
        c.instrDone = 1'b1;
      end
      BRANCH: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_B;
        c.aluOp = ALUOP_SUB;
        c.pcWriteCond = 1'b1;
        c.pcSource = PCSRC_ALUOUT;
        c.instrDone = 1'b1;
      end
      ADDI_WB: begin
        c.regWrite = 1'b1;
        c.instrDone = 1'b1;
      end
      JUMP: begin
        c.pcWrite = 1'b1;
        c.pcSource = PCSRC_JUMP;
        c.instrDone = 1'b1;
      end
      default: ;
    endcase
  end
  assign ctrlWord = c;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS sequencer with shared-memory ready stalls
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);
  logic [3:0] nextState;
  ctrlWord_t ctrl;
  // next state; unused encodings and all writeback-type states fall back to FETCH
  always_comb begin
    nextState = FETCH;
    case (state)
      IDLE:      nextState = FETCH;
      FETCH:     nextState = mem_ready ? DECODE : FETCH;
      DECODE:    nextState = opcode == OP_RTYPE ? EXECUTE :
                             (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                             opcode == OP_BEQ ? BRANCH :
                             opcode == OP_ADDI ? ADDI_EXEC :
                             opcode == OP_J ? JUMP : FETCH;
      MEM_ADDR:  nextState = opcode == OP_LW ? MEM_READ : MEM_WRITE;
      MEM_READ:  nextState = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: nextState = mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   nextState = R_WB;
      ADDI_EXEC: nextState = ADDI_WB;
      default:   nextState = FETCH;
    endcase
  end
  // state register with synchronous reset overriding any transition
  always_ff @(posedge clk)
    state <= reset ? IDLE : nextState;
  mc_output_decode u_decode (
    .state(state),
    .memReady(mem_ready),
    .ctrlWord(ctrl)
  );
  assign PCWrite = ctrl.pcWrite;
  assign PCWriteCond = ctrl.pcWriteCond;
  assign IorD = ctrl.iorD;
  assign MemRead = ctrl.memRead;
  assign MemWrite = ctrl.memWrite;
  assign MemtoReg = ctrl.memtoReg;
  assign IRWrite = ctrl.irWrite;
  assign RegWrite = ctrl.regWrite;
  assign RegDst = ctrl.regDst;
  assign ALUSrcA = ctrl.aluSrcA;
  assign ALUOp = ctrl.aluOp;
  assign ALUSrcB = ctrl.aluSrcB;
  assign PCSource = ctrl.pcSource;
  assign instr_done = ctrl.instrDone;
  assign illegal_op = state == DECODE && !isSupported(opcode);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and random instruction sequences against a phase-list model
module tb_multicycle_control;
  import mc_ctrl_pkg::*;
  logic clk = 1'b0, reset, mem_ready;
  logic [5:0] opcode;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic instr_done, illegal_op;
  logic [3:0] state;
  int tests = 0, fails = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  wire [17:0] gotCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                         RegWrite, RegDst, ALUSrcA, ALUOp, ALUSrcB, PCSource, instr_done, illegal_op};

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [17:0] expCtrl(input logic [3:0] s, input logic rdy, input logic [5:0] op);
    logic pcw, pcc, iod, mr, mw, m2r, irw, rw, rd, sa, dn, il;
    logic [1:0] aop, sb, ps;
    {pcw, pcc, iod, mr, mw, m2r, irw, rw, rd, sa, dn, il} = '0;
    {aop, sb, ps} = '0;
    case (s)
      FETCH:     begin mr = 1; sb = 2'b01; aop = 2'b10; irw = rdy; pcw = rdy; end
      DECODE:    begin sb = 2'b11; aop = 2'b10; il = !legal(op); end
      MEM_ADDR:  begin sa = 1; sb = 2'b10; aop = 2'b10; end
      MEM_READ:  begin mr = 1; iod = 1; end
      MEM_WB:    begin rw = 1; m2r = 1; dn = 1; end
      MEM_WRITE: begin mw = 1; iod = 1; dn = rdy; end
      EXECUTE:   sa = 1;
      R_WB:      begin rw = 1; rd = 1; dn = 1; end
      BRANCH:    begin sa = 1; aop = 2'b01; pcc = 1; ps = 2'b01; dn = 1; end
      ADDI_EXEC: begin sa = 1; sb = 2'b10; aop = 2'b10; end
      ADDI_WB:   begin rw = 1; dn = 1; end
      JUMP:      begin pcw = 1; ps = 2'b10; dn = 1; end
      default: ;
    endcase
    return {pcw, pcc, iod, mr, mw, m2r, irw, rw, rd, sa, aop, sb, ps, dn, il};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Builds the phase list of one instruction from its opcode and stall counts, then steps it.
  // Called at posedge+1 with the controller in FETCH; returns at posedge+1 of the next FETCH.
  task automatic runInstr(input logic [5:0] op, input int fs, input int ms);
    logic [3:0] q[$];
    logic r;
    for (int i = 0; i <= fs; i++) q.push_back(FETCH);
    q.push_back(DECODE);
    case (op)
      6'b000000: begin q.push_back(EXECUTE); q.push_back(R_WB); end
      6'b100011: begin
        q.push_back(MEM_ADDR);
        for (int i = 0; i <= ms; i++) q.push_back(MEM_READ);
        q.push_back(MEM_WB);
      end
      6'b101011: begin
        q.push_back(MEM_ADDR);
        for (int i = 0; i <= ms; i++) q.push_back(MEM_WRITE);
      end
      6'b000100: q.push_back(BRANCH);
      6'b001000: begin q.push_back(ADDI_EXEC); q.push_back(ADDI_WB); end
      6'b000010: q.push_back(JUMP);
      default: ;
    endcase
    opcode = op;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] inside {FETCH, MEM_READ, MEM_WRITE})
        r = (i + 1 == q.size()) || (q[i + 1] != q[i]);
      else
        r = 1'($urandom);
      mem_ready = r;
      #2;
      check($sformatf("op%02h cyc%0d state", op, i), 32'(state), 32'(q[i]));
      check($sformatf("op%02h cyc%0d ctrl", op, i), 32'(gotCtrl), 32'(expCtrl(q[i], r, op)));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'b0;
    @(posedge clk); #1;
    #2;
    check("reset state", 32'(state), 32'(IDLE));
    check("reset ctrl", 32'(gotCtrl), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    runInstr(6'b000000, 0, 0);
    runInstr(6'b100011, 0, 2);
    runInstr(6'b101011, 1, 0);
    runInstr(6'b000100, 0, 0);
    runInstr(6'b000010, 0, 0);
    runInstr(6'b111111, 0, 0);
    opcode = 6'b100011;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    #2;
    check("pre-reset state", 32'(state), 32'(MEM_READ));
    reset = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #2;
    check("midstall reset state", 32'(state), 32'(IDLE));
    check("midstall reset ctrl", 32'(gotCtrl), 32'(0));
    repeat (2) begin
      @(posedge clk); #1; #2;
      check("held reset state", 32'(state), 32'(IDLE));
    end
    reset = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 6) == 6) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      runInstr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
